// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth A/Q/Q-1 register file:
// FSM state type, booth_pair encodings and the arithmetic-shift helper
// used by both the datapath and its reference model.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } booth_shreg_state_t;

  // booth_pair = {Q[0], Q-1}
  localparam logic [1:0] BOOTH_NOP0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD  = 2'b01;
  localparam logic [1:0] BOOTH_SUB  = 2'b10;
  localparam logic [1:0] BOOTH_NOP1 = 2'b11;

  // Widest operand the shift helper can carry; {A,Q,Q-1} is zero-extended
  // into a vector of BOOTH_EXT_W bits before shifting.
  localparam int BOOTH_MAX_W = 32;
  localparam int BOOTH_EXT_W = 2 * BOOTH_MAX_W + 1;
  localparam logic [BOOTH_EXT_W-1:0] BOOTH_EXT_ONE = {{(BOOTH_EXT_W-1){1'b0}}, 1'b1};

  // Arithmetic right shift of {A,Q,Q-1}: t holds the triple in bits
  // [msb:0] (msb = 2*WIDTH) with zeros above. Bit msb is the sign of A
  // and is replicated; Q-1 falls off the bottom.
  function automatic logic [BOOTH_EXT_W-1:0] asr_aq(
    input logic [BOOTH_EXT_W-1:0] t,
    input int unsigned            msb
  );
    logic [BOOTH_EXT_W-1:0] sign_mask;
    sign_mask = BOOTH_EXT_ONE << msb;
    return (t >> 1) | (t & sign_mask);
  endfunction

endpackage

// File: rtl/booth_aq_shift_reg_if.sv
// Control and data bundle between the Booth sequencer/adder and the
// A/Q/Q-1 register file. cnt_out exists only when BOOTH_SHREG_CNT_OUT_EN
// is defined.
interface booth_aq_shift_reg_if #(
  parameter int WIDTH = 8
);
  logic               load;
  logic [WIDTH-1:0]   mult_in;
  logic [WIDTH-1:0]   a_in;
  logic               a_wr;
  logic               shift;
  logic [WIDTH-1:0]   a_out;
  logic [WIDTH-1:0]   q_out;
  logic               q_m1_out;
  logic [1:0]         booth_pair;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;
`ifdef BOOTH_SHREG_CNT_OUT_EN
  localparam int CNT_W = $clog2(WIDTH + 1);
  logic [CNT_W-1:0]   cnt_out;

  modport master (
    output load, mult_in, a_in, a_wr, shift,
    input  a_out, q_out, q_m1_out, booth_pair, product, busy, done, cnt_out
  );
  modport slave (
    input  load, mult_in, a_in, a_wr, shift,
    output a_out, q_out, q_m1_out, booth_pair, product, busy, done, cnt_out
  );
`else
  modport master (
    output load, mult_in, a_in, a_wr, shift,
    input  a_out, q_out, q_m1_out, booth_pair, product, busy, done
  );
  modport slave (
    input  load, mult_in, a_in, a_wr, shift,
    output a_out, q_out, q_m1_out, booth_pair, product, busy, done
  );
`endif
endinterface

// File: rtl/booth_step_counter.sv
// Remaining-shift counter for the Booth register file: loads WIDTH on
// start, decrements on each accepted shift and never wraps below zero.
module booth_step_counter #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: start value on load, otherwise saturating decrement
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(WIDTH);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register with synchronous clear
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/booth_aq_shift_reg.sv
// A/Q/Q-1 register file for a radix-2 Booth multiplier: captures the
// multiplier, accepts A write-back from the adder/subtractor, performs the
// arithmetic right shift of {A,Q,Q-1} and flags completion after WIDTH
// shifts. Optional macro BOOTH_SHREG_CNT_OUT_EN exposes the remaining
// shift count as bus.cnt_out.
module booth_aq_shift_reg
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 clear,
  booth_aq_shift_reg_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < 2 || WIDTH > BOOTH_MAX_W) begin : g_bad_width
    $error("booth_aq_shift_reg: WIDTH out of supported range");
  end

  booth_shreg_state_t state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   q_q;
  logic               q_m1_q;
  logic               busy_q;
  logic               done_q;

  logic [CNT_W-1:0]       cnt;
  logic                   cnt_zero;
  logic                   cnt_last;
  logic                   load_go;
  logic                   shift_go;
  logic [WIDTH-1:0]       a_new_d;
  logic [BOOTH_EXT_W-1:0] t_ext_d;
  logic [BOOTH_EXT_W-1:0] shr_ext_d;
  logic [2*WIDTH:0]       shifted_d;
  logic                   shr_hi_unused;

  // A start is only honoured outside RUN; shifts only count inside RUN
  assign load_go  = bus.load  && (state_q != RUN);
  assign shift_go = bus.shift && (state_q == RUN);

  booth_step_counter #(.WIDTH(WIDTH)) u_step_counter (
    .clk    (clk),
    .clear  (clear),
    .load_i (load_go),
    .dec_i  (shift_go),
    .cnt_o  (cnt),
    .zero_o (cnt_zero),
    .last_o (cnt_last)
  );

  // Shift candidate: the adder result (if written this cycle) joins Q/Q-1
  always_comb begin
    a_new_d   = bus.a_wr ? bus.a_in : a_q;
    t_ext_d   = BOOTH_EXT_W'({a_new_d, q_q, q_m1_q});
    shr_ext_d = asr_aq(t_ext_d, 2 * WIDTH);
    shifted_d = shr_ext_d[2*WIDTH:0];
  end

  // Bits above the triple are always zero; fold them away
  assign shr_hi_unused = ^shr_ext_d;

  // Sequencer and A/Q/Q-1 registers; busy/done are registered with the state
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      q_m1_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.load) begin
            a_q     <= '0;
            q_q     <= bus.mult_in;
            q_m1_q  <= 1'b0;
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          if (bus.shift) begin
            {a_q, q_q, q_m1_q} <= shifted_d;
            if (cnt_last) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else if (bus.a_wr) begin
            a_q <= bus.a_in;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // The counter must never be asked to go below zero while running
  always_ff @(posedge clk) begin
    if (!clear && (state_q == RUN) && bus.shift) begin
      assert (!cnt_zero)
        else $error("booth_aq_shift_reg: shift requested with zero count");
    end
  end

  assign bus.a_out      = a_q;
  assign bus.q_out      = q_q;
  assign bus.q_m1_out   = q_m1_q;
  assign bus.booth_pair = {q_q[0], q_m1_q};
  assign bus.product    = {a_q, q_q};
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

`ifdef BOOTH_SHREG_CNT_OUT_EN
  assign bus.cnt_out = cnt;
`else
  logic cnt_unused;
  assign cnt_unused = ^cnt;
`endif

endmodule

// File: tb/tb_booth_aq_shift_reg.sv
// Self-checking bench for booth_aq_shift_reg (WIDTH=8). A behavioural
// model predicts every cycle into a scoreboard queue; each scenario task
// drains and compares it, plus scenario-specific constant checks.
module tb_booth_aq_shift_reg;
  import booth_pkg::*;

  localparam int W = 8;

  typedef struct {
    string       tag;
    logic [15:0] product;
    logic [4:0]  flags;   // {busy, done, q_m1, booth_pair}
    logic [3:0]  cnt;
  } sb_t;

  logic clk;
  logic clear;
  int   checks;
  int   passed;

  sb_t exp_q[$];
  sb_t obs_q[$];

  // Reference model state
  logic [7:0] m_a;
  logic [7:0] m_q;
  logic       m_qm1;
  int         m_cnt;
  int         m_state;   // 0 idle, 1 run, 2 done

  booth_aq_shift_reg_if #(.WIDTH(W)) bus_if ();

  booth_aq_shift_reg #(.WIDTH(W)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Drive one cycle, predict its result, then capture the DUT response
  task automatic cycle(input logic clr, input logic ld, input logic [7:0] mi,
                       input logic [7:0] ai, input logic aw, input logic sh,
                       input string tag);
    sb_t e;
    sb_t o;
    logic [16:0] t;
    clear          = clr;
    bus_if.load    = ld;
    bus_if.mult_in = mi;
    bus_if.a_in    = ai;
    bus_if.a_wr    = aw;
    bus_if.shift   = sh;
    if (clr) begin
      m_a = 8'h00; m_q = 8'h00; m_qm1 = 1'b0; m_cnt = 0; m_state = 0;
    end else if (m_state != 1) begin
      if (ld) begin
        m_a = 8'h00; m_q = mi; m_qm1 = 1'b0; m_cnt = W; m_state = 1;
      end
    end else if (sh) begin
      t = {(aw ? ai : m_a), m_q, m_qm1};
      {m_a, m_q, m_qm1} = {t[16], t[16:1]};
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) m_state = 2;
    end else if (aw) begin
      m_a = ai;
    end
    e.tag     = tag;
    e.product = {m_a, m_q};
    e.flags   = {(m_state == 1), (m_state == 2), m_qm1, m_q[0], m_qm1};
    e.cnt     = 4'(m_cnt);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o.tag     = tag;
    o.product = bus_if.product;
    o.flags   = {bus_if.busy, bus_if.done, bus_if.q_m1_out, bus_if.booth_pair};
`ifdef BOOTH_SHREG_CNT_OUT_EN
    o.cnt     = bus_if.cnt_out;
`else
    o.cnt     = 4'h0;
`endif
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    sb_t e;
    sb_t o;
    cycle(1'b1, 1'b1, 8'hA5, 8'h3C, 1'b1, 1'b1, "reset0");
    cycle(1'b1, 1'b1, 8'h5A, 8'hC3, 1'b1, 1'b1, "reset1");
    checks++;
    if (bus_if.a_out !== 8'h00 || bus_if.q_out !== 8'h00 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0)
      $display("FAIL reset_const: got a=%h q=%h busy=%b done=%b, want all 0",
               bus_if.a_out, bus_if.q_out, bus_if.busy, bus_if.done);
    else passed++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("txn %s product=%h flags=%b cnt=%0d", o.tag, o.product, o.flags, o.cnt);
      checks++;
      if (o.product !== e.product) $display("FAIL %s product: got %h want %h", e.tag, o.product, e.product);
      else passed++;
      checks++;
      if (o.flags !== e.flags) $display("FAIL %s flags: got %b want %b", e.tag, o.flags, e.flags);
      else passed++;
`ifdef BOOTH_SHREG_CNT_OUT_EN
      checks++;
      if (o.cnt !== e.cnt) $display("FAIL %s cnt_out: got %0d want %0d", e.tag, o.cnt, e.cnt);
      else passed++;
`endif
    end
  endtask

  task automatic test_shift_only();
    sb_t e;
    sb_t o;
    logic [7:0] q_seq [8] = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic       m1_seq[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    cycle(1'b0, 1'b1, 8'h05, 8'h00, 1'b0, 1'b0, "so_load");
    checks++;
    if (bus_if.q_out !== 8'h05 || bus_if.busy !== 1'b1)
      $display("FAIL so_load_const: got q=%h busy=%b, want q=05 busy=1", bus_if.q_out, bus_if.busy);
    else passed++;
`ifdef BOOTH_SHREG_CNT_OUT_EN
    checks++;
    if (bus_if.cnt_out !== 4'd8) $display("FAIL so_cnt_load: got %0d want 8", bus_if.cnt_out);
    else passed++;
`endif
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, "so_shift");
      checks++;
      if (bus_if.q_out !== q_seq[k] || bus_if.q_m1_out !== m1_seq[k] || bus_if.done !== (k == 7))
        $display("FAIL so_step%0d: got q=%h qm1=%b done=%b, want q=%h qm1=%b done=%b",
                 k + 1, bus_if.q_out, bus_if.q_m1_out, bus_if.done, q_seq[k], m1_seq[k], (k == 7));
      else passed++;
    end
    checks++;
    if (bus_if.busy !== 1'b0) $display("FAIL so_busy_end: got %b want 0", bus_if.busy);
    else passed++;
    cycle(1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b1, "so_done_hold");
    cycle(1'b0, 1'b0, 8'h00, 8'h81, 1'b1, 1'b0, "so_done_hold");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("txn %s product=%h flags=%b cnt=%0d", o.tag, o.product, o.flags, o.cnt);
      checks++;
      if (o.product !== e.product) $display("FAIL %s product: got %h want %h", e.tag, o.product, e.product);
      else passed++;
      checks++;
      if (o.flags !== e.flags) $display("FAIL %s flags: got %b want %b", e.tag, o.flags, e.flags);
      else passed++;
`ifdef BOOTH_SHREG_CNT_OUT_EN
      checks++;
      if (o.cnt !== e.cnt) $display("FAIL %s cnt_out: got %0d want %0d", e.tag, o.cnt, e.cnt);
      else passed++;
`endif
    end
  endtask

  task automatic test_write_shift();
    sb_t e;
    sb_t o;
    cycle(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, "ws_load");
    cycle(1'b0, 1'b0, 8'h00, 8'hF4, 1'b1, 1'b1, "ws_wrshift");
    checks++;
    if (bus_if.a_out !== 8'hFA || bus_if.q_out !== 8'h7F || bus_if.q_m1_out !== 1'b1 || bus_if.busy !== 1'b1)
      $display("FAIL ws_const: got a=%h q=%h qm1=%b busy=%b, want a=FA q=7F qm1=1 busy=1",
               bus_if.a_out, bus_if.q_out, bus_if.q_m1_out, bus_if.busy);
    else passed++;
`ifdef BOOTH_SHREG_CNT_OUT_EN
    checks++;
    if (bus_if.cnt_out !== 4'd7) $display("FAIL ws_cnt: got %0d want 7", bus_if.cnt_out);
    else passed++;
`endif
    cycle(1'b0, 1'b0, 8'h00, 8'h3C, 1'b1, 1'b0, "ws_wronly");
    checks++;
    if (bus_if.a_out !== 8'h3C || bus_if.q_out !== 8'h7F)
      $display("FAIL ws_wronly_const: got a=%h q=%h, want a=3C q=7F", bus_if.a_out, bus_if.q_out);
    else passed++;
    cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "ws_clear");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("txn %s product=%h flags=%b cnt=%0d", o.tag, o.product, o.flags, o.cnt);
      checks++;
      if (o.product !== e.product) $display("FAIL %s product: got %h want %h", e.tag, o.product, e.product);
      else passed++;
      checks++;
      if (o.flags !== e.flags) $display("FAIL %s flags: got %b want %b", e.tag, o.flags, e.flags);
      else passed++;
`ifdef BOOTH_SHREG_CNT_OUT_EN
      checks++;
      if (o.cnt !== e.cnt) $display("FAIL %s cnt_out: got %0d want %0d", e.tag, o.cnt, e.cnt);
      else passed++;
`endif
    end
  endtask

  task automatic test_multiply();
    sb_t e;
    sb_t o;
    logic [7:0] mcand;
    logic [7:0] ain;
    logic [1:0] pair;
    mcand = 8'hFD;
    cycle(1'b0, 1'b1, 8'h07, 8'h00, 1'b0, 1'b0, "mul_load");
    for (int k = 0; k < 8; k++) begin
      pair = {m_q[0], m_qm1};
      ain  = (pair == BOOTH_ADD) ? 8'(m_a + mcand) :
             (pair == BOOTH_SUB) ? 8'(m_a - mcand) : m_a;
      cycle(1'b0, 1'b0, 8'h00, ain, (pair == BOOTH_ADD || pair == BOOTH_SUB), 1'b1, "mul_step");
    end
    checks++;
    if (bus_if.product !== 16'hFFEB || bus_if.done !== 1'b1)
      $display("FAIL mul_const: got product=%h done=%b, want product=FFEB done=1",
               bus_if.product, bus_if.done);
    else passed++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("txn %s product=%h flags=%b cnt=%0d", o.tag, o.product, o.flags, o.cnt);
      checks++;
      if (o.product !== e.product) $display("FAIL %s product: got %h want %h", e.tag, o.product, e.product);
      else passed++;
      checks++;
      if (o.flags !== e.flags) $display("FAIL %s flags: got %b want %b", e.tag, o.flags, e.flags);
      else passed++;
`ifdef BOOTH_SHREG_CNT_OUT_EN
      checks++;
      if (o.cnt !== e.cnt) $display("FAIL %s cnt_out: got %0d want %0d", e.tag, o.cnt, e.cnt);
      else passed++;
`endif
    end
  endtask

  task automatic test_load_in_run_and_clear();
    sb_t e;
    sb_t o;
    cycle(1'b0, 1'b1, 8'h33, 8'h00, 1'b0, 1'b0, "lr_load");
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, "lr_shift");
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, "lr_shift");
    cycle(1'b0, 1'b1, 8'hAA, 8'h00, 1'b0, 1'b1, "lr_shift_load");
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, "lr_shift");
      checks++;
      if (bus_if.done !== (k == 4))
        $display("FAIL lr_done_step%0d: got %b want %b", k + 1, bus_if.done, (k == 4));
      else passed++;
    end
    cycle(1'b0, 1'b1, 8'h5A, 8'h00, 1'b0, 1'b0, "lr_reload");
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, "lr_shift");
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, "lr_shift");
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, "lr_shift");
    cycle(1'b1, 1'b0, 8'h00, 8'h77, 1'b1, 1'b1, "lr_clear");
    checks++;
    if (bus_if.product !== 16'h0000 || bus_if.q_m1_out !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0)
      $display("FAIL lr_clear_const: got product=%h qm1=%b busy=%b done=%b, want all 0",
               bus_if.product, bus_if.q_m1_out, bus_if.busy, bus_if.done);
    else passed++;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("txn %s product=%h flags=%b cnt=%0d", o.tag, o.product, o.flags, o.cnt);
      checks++;
      if (o.product !== e.product) $display("FAIL %s product: got %h want %h", e.tag, o.product, e.product);
      else passed++;
      checks++;
      if (o.flags !== e.flags) $display("FAIL %s flags: got %b want %b", e.tag, o.flags, e.flags);
      else passed++;
`ifdef BOOTH_SHREG_CNT_OUT_EN
      checks++;
      if (o.cnt !== e.cnt) $display("FAIL %s cnt_out: got %0d want %0d", e.tag, o.cnt, e.cnt);
      else passed++;
`endif
    end
  endtask

  // Random signed multiplies, back to back from DONE, with add/sub steps
  // sometimes split into a write cycle followed by a shift cycle
  task automatic test_back_to_back();
    sb_t e;
    sb_t o;
    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic [7:0]  ain;
    logic [1:0]  pair;
    logic [15:0] want;
    int          sm;
    int          sq;
    for (int p = 0; p < 4; p++) begin
      mcand  = 8'($urandom);
      mplier = 8'($urandom);
      if (mcand == 8'h80) mcand = 8'h81;
      sm   = $signed(mcand);
      sq   = $signed(mplier);
      want = 16'(sm * sq);
      cycle(1'b0, 1'b1, mplier, 8'h00, 1'b0, 1'b0, "b2b_load");
      for (int k = 0; k < 8; k++) begin
        pair = {m_q[0], m_qm1};
        ain  = (pair == BOOTH_ADD) ? 8'(m_a + mcand) :
               (pair == BOOTH_SUB) ? 8'(m_a - mcand) : m_a;
        if ((pair == BOOTH_ADD || pair == BOOTH_SUB) && ($urandom_range(0, 1) == 1)) begin
          cycle(1'b0, 1'b0, 8'h00, ain, 1'b1, 1'b0, "b2b_write");
          cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, "b2b_shift");
        end else begin
          cycle(1'b0, 1'b0, 8'h00, ain, (pair == BOOTH_ADD || pair == BOOTH_SUB), 1'b1, "b2b_step");
        end
      end
      checks++;
      if (bus_if.product !== want || bus_if.done !== 1'b1)
        $display("FAIL b2b_product %h*%h: got %h done=%b, want %h done=1",
                 mcand, mplier, bus_if.product, bus_if.done, want);
      else passed++;
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("txn %s product=%h flags=%b cnt=%0d", o.tag, o.product, o.flags, o.cnt);
      checks++;
      if (o.product !== e.product) $display("FAIL %s product: got %h want %h", e.tag, o.product, e.product);
      else passed++;
      checks++;
      if (o.flags !== e.flags) $display("FAIL %s flags: got %b want %b", e.tag, o.flags, e.flags);
      else passed++;
`ifdef BOOTH_SHREG_CNT_OUT_EN
      checks++;
      if (o.cnt !== e.cnt) $display("FAIL %s cnt_out: got %0d want %0d", e.tag, o.cnt, e.cnt);
      else passed++;
`endif
    end
  endtask

  initial begin
    checks         = 0;
    passed         = 0;
    m_a            = 8'h00;
    m_q            = 8'h00;
    m_qm1          = 1'b0;
    m_cnt          = 0;
    m_state        = 0;
    clear          = 1'b1;
    bus_if.load    = 1'b0;
    bus_if.mult_in = 8'h00;
    bus_if.a_in    = 8'h00;
    bus_if.a_wr    = 1'b0;
    bus_if.shift   = 1'b0;
    test_reset();
    test_shift_only();
    test_write_shift();
    test_multiply();
    test_load_in_run_and_clear();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
